dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder serving the MEM-stage load/store initiator over a valid/ready

---
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle doubleword data memory behind a valid/ready request/response handshake.
// Dwords 0..7 are preloaded from the element inputs while reset is held low.
module dmem_responder #(
    parameter int DEPTH_DW = 64,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] element1,
    input  logic [63:0] element2,
    input  logic [63:0] element3,
    input  logic [63:0] element4,
    input  logic [63:0] element5,
    input  logic [63:0] element6,
    input  logic [63:0] element7,
    input  logic [63:0] element8,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_be,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW         = $clog2(DEPTH_DW);
    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_DW) * 64'd8;
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [3:0]    cnt_r;
    logic [AW-1:0] idx_r;
    logic          write_r;
    logic [7:0]    be_r;
    logic [63:0]   wdata_r;
    logic [63:0]   rsp_rdata_r;
    logic          rsp_err_r;
    logic          bad_req_s;
    logic          accept_s;
    logic          access_s;
    logic          req_ready_s;
    logic          rsp_valid_s;
    logic          busy_s;
    logic [63:0]   preload_s [8];
    logic [63:0]   mem_q_s   [DEPTH_DW];

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_dw,
                                                input logic [63:0] new_dw,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_dw;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_dw[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Full 64-bit compare so high address bits can never alias into the array.
    assign bad_req_s = (req_addr[2:0] != 3'd0) || (req_addr >= BYTE_LIMIT);
    assign accept_s  = req_valid && (state_r == IDLE);
    assign access_s  = (state_r == WAIT) && (cnt_r == 4'd0);
    assign preload_s = '{element1, element2, element3, element4,
                         element5, element6, element7, element8};

    for (genvar g = 0; g < DEPTH_DW; g++) begin : gen_dw
        localparam logic [AW-1:0] G_IDX = AW'(g);
        logic [63:0] dw_r;
        if (g < 8) begin : gen_pre
            // Preloaded dword: follows its element input while reset is held.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dw_r <= preload_s[g];
                end else if (access_s && write_r && (idx_r == G_IDX)) begin
                    dw_r <= merge_bytes(dw_r, wdata_r, be_r);
                end
            end
        end else begin : gen_clr
            // Plain dword: clears on reset, byte-merged on an enabled store.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dw_r <= 64'd0;
                end else if (access_s && write_r && (idx_r == G_IDX)) begin
                    dw_r <= merge_bytes(dw_r, wdata_r, be_r);
                end
            end
        end
        assign mem_q_s[g] = dw_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = bad_req_s ? RESP : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            WAIT:    rsp_valid_s = 1'b0;
            RESP:    rsp_valid_s = 1'b1;
            default: busy_s      = 1'b1;
        endcase
    end

    // Request capture and wait counter; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            write_r <= 1'b0;
            be_r    <= 8'd0;
            wdata_r <= 64'd0;
        end else if (accept_s) begin
            cnt_r   <= CNT_INIT;
            idx_r   <= req_addr[AW+2:3];
            write_r <= req_write;
            be_r    <= req_be;
            wdata_r <= req_wdata;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response data/error registers, held stable throughout RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else if (accept_s && bad_req_s) begin
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b1;
        end else if (access_s) begin
            rsp_rdata_r <= write_r ? 64'd0 : mem_q_s[idx_r];
            rsp_err_r   <= 1'b0;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign busy      = busy_s;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of transactions plus
// hand-written latency, backpressure and reset-during-access sequences.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic [63:0] element1, element2, element3, element4;
    logic [63:0] element5, element6, element7, element8;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    dmem_responder #(.DEPTH_DW(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .element1(element1), .element2(element2), .element3(element3), .element4(element4),
        .element5(element5), .element6(element6), .element7(element7), .element8(element8),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One complete transaction, checking accept, latency, response and handshake.
    task automatic run_txn(input vec_t v, input int k);
        int cyc;
        int exp_lat;
        exp_lat = v.exp_err ? 1 : LAT + 1;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", k), 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_be    = v.be;
        req_wdata = v.wdata;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 64'h0000_0000_0000_0018;
        req_be    = 8'hFF;
        req_wdata = ~v.wdata;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d latency", k), 64'(cyc), 64'(exp_lat));
        chk($sformatf("v%0d rdata", k), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d err", k), 64'(rsp_err), 64'(v.exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d done", k), {62'd0, rsp_valid, busy}, 64'd0);
    endtask

    initial begin
        element1 = 64'd1; element2 = 64'd2; element3 = 64'd3; element4 = 64'd4;
        element5 = 64'd5; element6 = 64'd6; element7 = 64'd7; element8 = 64'd8;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_be = 8'd0;
        req_wdata = 64'd0; rsp_ready = 1'b0;

        vecs[0]  = '{1'b0, 64'h38, 8'h00, 64'd0, 64'd8, 1'b0};
        vecs[1]  = '{1'b0, 64'h40, 8'h00, 64'd0, 64'd0, 1'b0};
        vecs[2]  = '{1'b1, 64'h10, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b0};
        vecs[3]  = '{1'b0, 64'h10, 8'h00, 64'd0, 64'h0000_0000_CCCC_DDDD, 1'b0};
        vecs[4]  = '{1'b0, 64'h0C, 8'h00, 64'd0, 64'd0, 1'b1};
        vecs[5]  = '{1'b0, 64'h200, 8'h00, 64'd0, 64'd0, 1'b1};
        vecs[6]  = '{1'b0, 64'h8000_0000_0000_0008, 8'h00, 64'd0, 64'd0, 1'b1};
        vecs[7]  = '{1'b0, 64'h08, 8'h00, 64'd0, 64'd2, 1'b0};
        vecs[8]  = '{1'b1, 64'h1F8, 8'h80, 64'h1122_3344_5566_7788, 64'd0, 1'b0};
        vecs[9]  = '{1'b0, 64'h1F8, 8'h00, 64'd0, 64'h1100_0000_0000_0000, 1'b0};
        vecs[10] = '{1'b1, 64'h18, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0};
        vecs[11] = '{1'b0, 64'h18, 8'h00, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[12] = '{1'b1, 64'h20, 8'hA5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[13] = '{1'b0, 64'h20, 8'h00, 64'd0, 64'hFF00_FF00_00FF_00FF, 1'b0};
        vecs[14] = '{1'b1, 64'h2C, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[15] = '{1'b0, 64'h28, 8'h00, 64'd0, 64'd6, 1'b0};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i], i);
        end

        // Cycle-accurate load timing with rsp_ready held low, then backpressure.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0; rsp_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("lat c%0d busy", c), 64'(busy), 64'd1);
            chk($sformatf("lat c%0d req_ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("lat c%0d rsp_valid", c), 64'(rsp_valid), (c == 3) ? 64'd1 : 64'd0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
            chk($sformatf("hold c%0d rdata", c), rsp_rdata, 64'd1);
        end
        // A request offered during the handshake cycle must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 64'h08;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("handshake rsp_valid", 64'(rsp_valid), 64'd0);
        chk("handshake no accept", 64'(busy), 64'd0);

        // Reset while a store is waiting: it must be discarded.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08; req_be = 8'hFF;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid reset req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post reset busy", 64'(busy), 64'd0);
        run_txn('{1'b0, 64'h08, 8'h00, 64'd0, 64'd2, 1'b0}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
